// File: rtl/cdc_seq_pkg.sv
// Shared types and constants for the datapath operation sequencer.
// Imported by the sequencer top and its timeout counter.
package cdc_seq_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int FRAME_BITS = 2 * DATA_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HANDOFF,
        COLLECT,
        RESP
    } seq_state_e;

    localparam logic [1:0] DP_IDLE      = 2'd0;
    localparam logic [1:0] DP_SHIFT_IN  = 2'd1;
    localparam logic [1:0] DP_WAIT      = 2'd2;
    localparam logic [1:0] DP_SHIFT_OUT = 2'd3;

    function automatic int frame_bits(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Cycle counter bounding the HANDOFF+COLLECT phase of one operation.
// expired is high during the last permitted cycle of that phase.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cdc_op_sequencer.sv
// Host-side sequencer: serializes {A,B} into the datapath, hands off,
// collects the returned {B,C} frame and presents it as a response.
module cdc_op_sequencer
    import cdc_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    input  logic [2:0]            req_op_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_b_o,
    output logic [DATA_WIDTH-1:0] rsp_c_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  dp_en_o,
    output logic [2:0]            dp_ctl_o,
    output logic                  dp_new_data_o,
    output logic                  dp_data_o,
    output logic                  dp_done_shifting_o,
    input  logic                  dp_data_i,
    input  logic                  dp_new_data_i,
    input  logic [1:0]            dp_state_i
);

    localparam int FB = frame_bits(DATA_WIDTH);
    localparam int CW = $clog2(FB + 1);

    seq_state_e state, state_nx;

    logic [FB-1:0] tx;
    logic [FB-1:0] rx;
    logic [FB-1:0] rx_nx;
    logic [CW-1:0] load_cnt;
    logic [CW-1:0] rx_cnt;
    logic [CW-1:0] rx_cnt_nx;
    logic [2:0]    ctl;
    logic          err;
    logic          accept;
    logic          sample;
    logic          tmo;
    logic          tmo_run;

    assign accept  = en_i && (state == IDLE) && req_valid_i;
    assign sample  = (state == COLLECT) && (dp_state_i == DP_SHIFT_OUT);
    assign tmo_run = en_i && ((state == HANDOFF) || (state == COLLECT));

    // Capture happens before the frame-length check on the same cycle.
    assign rx_nx = sample ? {rx[FB-2:0], dp_data_i} : rx;
    assign rx_cnt_nx = (sample && (rx_cnt != CW'(FB)))
                     ? rx_cnt + 1'b1 : rx_cnt;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .enable (tmo_run),
        .clear  (accept),
        .expired(tmo)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else if (en_i) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid_i) state_nx = LOAD;
            end
            LOAD: begin
                if (load_cnt == CW'(FB - 1)) state_nx = HANDOFF;
            end
            HANDOFF: begin
                state_nx = COLLECT;
            end
            COLLECT: begin
                if (dp_new_data_i || tmo) state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx       <= '0;
            rx       <= '0;
            load_cnt <= '0;
            rx_cnt   <= '0;
            ctl      <= '0;
            err      <= 1'b0;
        end else if (en_i) begin
            if (accept) begin
                tx       <= {req_a_i, req_b_i};
                ctl      <= req_op_i;
                load_cnt <= '0;
                rx       <= '0;
                rx_cnt   <= '0;
                err      <= 1'b0;
            end
            if (state == LOAD) begin
                tx       <= {tx[FB-2:0], 1'b0};
                load_cnt <= load_cnt + 1'b1;
            end
            if (state == COLLECT) begin
                rx     <= rx_nx;
                rx_cnt <= rx_cnt_nx;
                // A real end-of-frame pulse wins over a same-cycle timeout.
                if (dp_new_data_i) begin
                    err <= (rx_cnt_nx != CW'(FB));
                end else if (tmo) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o        = en_i && (state == IDLE);
    assign rsp_valid_o        = (state == RESP);
    assign rsp_b_o            = rx[FB-1:DATA_WIDTH];
    assign rsp_c_o            = rx[DATA_WIDTH-1:0];
    assign rsp_err_o          = err;
    assign busy_o             = (state != IDLE);
    assign dp_en_o            = en_i;
    assign dp_ctl_o           = ctl;
    assign dp_new_data_o      = en_i && (state == LOAD);
    assign dp_data_o          = (state == LOAD) && tx[FB-1];
    assign dp_done_shifting_o = en_i && (state == HANDOFF);

endmodule

// File: doc/cdc_op_sequencer.md
Name: cdc_op_sequencer

Overview:
- Host-side controller for one clock_domain_module datapath instance.
- Accepts one operation per request (8-bit A, 8-bit B, 3-bit op) over a valid/ready port and serializes {A,B} into the datapath's input shifter.
- Hands off to the datapath FSM, then deserializes the returned {B,C} stream and presents it on a valid/ready response port with an error flag.
- Both datapath clock inputs are driven from clk_i in this configuration.

Parameters:
- DATA_WIDTH, 8, operand/result byte width; serial frame is 2*DATA_WIDTH bits.
- TIMEOUT_CYCLES, 255, maximum cycles spent in HANDOFF+COLLECT before aborting with error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  global enable; low freezes all state.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_a_i  in  DATA_WIDTH  operand A.
- req_b_i  in  DATA_WIDTH  operand B.
- req_op_i  in  3  ALU control code.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_b_o  out  DATA_WIDTH  returned B byte.
- rsp_c_o  out  DATA_WIDTH  returned C byte (ALU result).
- rsp_err_o  out  1  timeout or short frame.
- busy_o  out  1  state != IDLE.
- dp_en_o  out  1  datapath enable (= en_i).
- dp_ctl_o  out  3  latched op to datapath ctl_i.
- dp_new_data_o  out  1  datapath new_data_i (input shift strobe).
- dp_data_o  out  1  datapath serial data_i.
- dp_done_shifting_o  out  1  datapath done_shifting_i.
- dp_data_i  in  1  datapath serial data_o.
- dp_new_data_i  in  1  datapath new_data_o (end-of-output pulse).
- dp_state_i  in  2  datapath current_state_o.

Behaviour:
Reset (rst_ni low, async):
- State IDLE; all outputs 0 except req_ready_o=1.
- Registers cleared.
- Reset mid-operation aborts with no response.

en_i low:
- No state, counter or register changes.
- req_ready_o=0; rsp_valid_o holds its value.
- dp_new_data_o=0, dp_done_shifting_o=0.

IDLE:
- req_ready_o=1.
- On req_valid_i&req_ready_o: latch {A,B} into a 16-bit TX shift register and op into dp_ctl_o; clear bit counter, RX register and err; go LOAD.

LOAD (exactly 2*DATA_WIDTH cycles):
- dp_new_data_o=1.
- dp_data_o = TX MSB, MSB first: A[7] on the first LOAD cycle, B[0] on the 16th.
- Counter 0..15; on count 15 go HANDOFF.

HANDOFF (1 cycle):
- dp_done_shifting_o=1; go COLLECT.

COLLECT:
- On each cycle with dp_state_i==DP_SHIFT_OUT (2'd3), shift dp_data_i into the LSB of the 16-bit RX register.
- RX bit counter saturates at 16.
- On dp_new_data_i: go RESP; err = (rx_count != 16).

Timeout:
- Counter runs in HANDOFF and COLLECT.
- Reaching TIMEOUT_CYCLES forces RESP with err=1; RX contents are presented as-is.

RESP:
- rsp_valid_o=1; rsp_b_o=RX[15:8], rsp_c_o=RX[7:0], rsp_err_o=err. Outputs are stable while valid&~ready.
- On rsp_ready_i: go IDLE.
- req_ready_o stays 0 until the cycle after acceptance.

Latency:
- Acceptance in cycle 0, LOAD in cycles 1–16, HANDOFF in cycle 17, COLLECT from cycle 18.

Simultaneous events:
- dp_new_data_i on the same cycle as a sampled bit: the bit is captured first, then err is evaluated.
- Timeout on the same cycle as dp_new_data_i: the normal completion wins.
- More than 16 sampled bits: the register keeps the last 16, with no error.
- req_valid_i outside IDLE is ignored (ready=0).

Decomposition:
- Package cdc_seq_pkg holds:
  - state enum {IDLE, LOAD, HANDOFF, COLLECT, RESP};
  - datapath state constants DP_IDLE=0, DP_SHIFT_IN=1, DP_WAIT=2, DP_SHIFT_OUT=3;
  - FRAME_BITS = 2*DATA_WIDTH.
- One sub-module, seq_timeout_counter: enable, clear, expiry flag, parameter TIMEOUT_CYCLES.

Test Plan:
- Reset then A=8'h3C, B=8'h05, op=3'd0 with a real datapath -> dp_data_o sequence 0011_1100_0000_0101 in cycles 1–16, dp_done_shifting_o in cycle 17, rsp_b_o=8'h05, rsp_c_o=ALU(op,8'h3C,8'h05), rsp_err_o=0.
- Behavioral datapath returns 16 bits 16'hA55A then pulses dp_new_data_i -> rsp_b_o=8'hA5, rsp_c_o=8'h5A, err=0; rsp_ready_i held low 5 cycles -> outputs stable; req_ready_o low during that time.
- Model never pulses dp_new_data_i -> RESP with rsp_err_o=1 exactly TIMEOUT_CYCLES cycles after HANDOFF entry; next request completes normally.
- Model returns 12 bits then pulses dp_new_data_i -> err=1; returns 20 bits -> last 16 bits presented, err=0.
- en_i dropped for 4 cycles mid-LOAD -> dp_new_data_o=0 for those cycles, bit index resumes, full 16-bit frame still correct; rst_ni asserted mid-COLLECT -> immediate IDLE, req_ready_o=1, no rsp_valid_o.
- Back-to-back: rsp_ready_i=1 while req_valid_i=1 constantly -> second request accepted the cycle after RESP exits, with no lost or duplicated response.
